// File: rtl/serializador_bits.sv
// Parallel-to-serial front end for the serial sequence detector.
// Accepts WIDTH-bit words over valid/ready into a one-word holding register
// and shifts them out one bit per clock, with an optional idle gap between
// words. With GAP=0 consecutive words stream without a bubble because the
// hold register is loaded into the shifter on the same edge the last bit leaves.
module serializador_bits #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out,
  output logic             out_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   BIT_LAST = CW'(WIDTH - 1);
  // Only meaningful when GAP>0; the GAP state is unreachable otherwise.
  localparam logic [7:0]      GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;

  logic             bit_last;
  logic             gap_last;
  logic             load_now;
  logic             xfer;

  // Control state registers; reset aborts any word in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Holding register data; its contents only matter while hold_full_q is set.
  always_ff @(posedge clk) begin
    if (xfer) begin
      hold_q <= data_in;
    end
  end

  // Handshake, next-state logic and outputs (outputs depend on registered state only).
  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    out         = IDLE_BIT;
    out_valid   = 1'b0;
    last_bit    = 1'b0;

    bit_last = (bit_cnt_q == BIT_LAST);
    gap_last = (gap_cnt_q == GAP_LAST);
    load_now = hold_full_q &&
               ((state_q == S_IDLE) ||
                ((state_q == S_SHIFT) && bit_last && (GAP == 0)) ||
                ((state_q == S_GAP) && gap_last));

    data_ready = !hold_full_q || load_now;
    xfer       = data_valid && data_ready;
    busy       = (state_q != S_IDLE) || hold_full_q;

    if (xfer) begin
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // Word starts from the load below.
      end
      S_SHIFT: begin
        out       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        out_valid = 1'b1;
        last_bit  = bit_last;
        shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
        if (!bit_last) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          bit_cnt_d = '0;
          if (!load_now) begin
            if (GAP > 0) begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_GAP: begin
        if (!gap_last) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end else begin
          gap_cnt_d = '0;
          if (!load_now) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Hold-to-shifter load overrides the per-state updates above.
    if (load_now) begin
      shreg_d     = hold_q;
      bit_cnt_d   = '0;
      state_d     = S_SHIFT;
      hold_full_d = xfer;
    end
  end

endmodule

// File: tb/tb_serializador_bits.sv
// Directed bench for serializador_bits: three instances (MSB-first GAP=0,
// LSB-first GAP=0, MSB-first GAP=3) share clock and reset.
module tb_serializador_bits;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din [3];
  logic [2:0] dv;
  logic [2:0] dr, so, ov, lb, bz;

  int checks   = 0;
  int failures = 0;

  logic rec_ov [64];
  logic rec_so [64];
  logic rec_dr [64];
  logic rec_lb [64];
  logic rec_bz [64];

  always #5 clk = ~clk;

  serializador_bits #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .data_in(din[0]), .data_valid(dv[0]), .data_ready(dr[0]),
    .out(so[0]), .out_valid(ov[0]), .last_bit(lb[0]), .busy(bz[0]));

  serializador_bits #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(din[1]), .data_valid(dv[1]), .data_ready(dr[1]),
    .out(so[1]), .out_valid(ov[1]), .last_bit(lb[1]), .busy(bz[1]));

  serializador_bits #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(3), .IDLE_BIT(1'b0)) u_gap (
    .clk(clk), .rst(rst), .data_in(din[2]), .data_valid(dv[2]), .data_ready(dr[2]),
    .out(so[2]), .out_valid(ov[2]), .last_bit(lb[2]), .busy(bz[2]));

  typedef struct {
    int         k;
    logic [7:0] w;
    logic [7:0] exp;   // bits in transmission order, exp[7] first
    string      nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Single word on an idle instance; called just after a rising edge.
  task automatic run_word(input int k, input logic [7:0] w, input logic [7:0] exp, input string nm);
    chk({nm, "_rdy"}, 32'(dr[k]), 32'd1);
    dv[k]  = 1'b1;
    din[k] = w;
    @(posedge clk); #1;
    dv[k]  = 1'b0;
    din[k] = ~w;
    @(negedge clk);
    chk({nm, "_lat"}, 32'(ov[k]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk({nm, "_ov"},   32'(ov[k]), 32'd1);
      chk({nm, "_bit"},  32'(so[k]), 32'(exp[7-i]));
      chk({nm, "_last"}, 32'(lb[k]), 32'(i == 7));
    end
    @(negedge clk);
    chk({nm, "_end_ov"},   32'(ov[k]), 32'd0);
    chk({nm, "_end_out"},  32'(so[k]), 32'd0);
    chk({nm, "_end_busy"}, 32'(bz[k]), 32'd0);
    @(posedge clk); #1;
  endtask

  // Source keeps data_valid high while words remain; data_in is junk whenever
  // data_ready is low, so only handshake-edge values may be serialized.
  task automatic stream(input int k, input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input int nw, input int ncyc);
    logic [7:0] ws [3];
    int         i;
    logic       xf;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    i      = 0;
    dv[k]  = 1'b1;
    din[k] = ws[0];
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rec_ov[c] = ov[k];
      rec_so[c] = so[k];
      rec_dr[c] = dr[k];
      rec_lb[c] = lb[k];
      rec_bz[c] = bz[k];
      xf = dv[k] & dr[k];
      @(posedge clk); #1;
      if (xf) i++;
      dv[k] = (i < nw);
      if (dr[k] && (i < nw)) din[k] = ws[i];
      else                   din[k] = 8'((c * 37) ^ 231);
    end
    dv[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t       tbl [7];
    logic [23:0] s24;
    logic [15:0] s16;
    logic [23:0] got;
    int          nbits;

    tbl[0] = '{0, 8'hB0, 8'b1011_0000, "msb_b0"};
    tbl[1] = '{1, 8'h0D, 8'b1011_0000, "lsb_0d"};
    tbl[2] = '{0, 8'h01, 8'b0000_0001, "msb_01"};
    tbl[3] = '{1, 8'h01, 8'b1000_0000, "lsb_01"};
    tbl[4] = '{1, 8'h80, 8'b0000_0001, "lsb_80"};
    tbl[5] = '{1, 8'h12, 8'b0100_1000, "lsb_12"};
    tbl[6] = '{0, 8'hA5, 8'b1010_0101, "msb_a5"};

    rst = 1'b1;
    dv  = 3'b000;
    for (int k = 0; k < 3; k++) din[k] = 8'h00;
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("reset_out",   32'(so[k]), 32'd0);
      chk("reset_ov",    32'(ov[k]), 32'd0);
      chk("reset_last",  32'(lb[k]), 32'd0);
      chk("reset_busy",  32'(bz[k]), 32'd0);
      chk("reset_ready", 32'(dr[k]), 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int j = 0; j < 7; j++) begin
      run_word(tbl[j].k, tbl[j].w, tbl[j].exp, tbl[j].nm);
    end

    // Back-to-back A5,3C,FF with GAP=0: 24 bits with no bubble.
    stream(0, 8'hA5, 8'h3C, 8'hFF, 3, 30);
    s24 = 24'hA53CFF;
    for (int c = 0; c < 30; c++) begin
      chk("b2b_ov",    32'(rec_ov[c]), 32'(c >= 2 && c <= 25));
      chk("b2b_ready", 32'(rec_dr[c]), 32'(!((c >= 2 && c <= 8) || (c >= 10 && c <= 16))));
      chk("b2b_last",  32'(rec_lb[c]), 32'(c == 9 || c == 17 || c == 25));
      if (c >= 2 && c <= 25) chk("b2b_bit", 32'(rec_so[c]), 32'(s24[25-c]));
      else                   chk("b2b_idle", 32'(rec_so[c]), 32'd0);
    end

    // GAP=3: exactly three idle cycles between two back-to-back words.
    stream(2, 8'hC1, 8'h5A, 8'h00, 2, 26);
    s16 = 16'hC15A;
    for (int c = 0; c < 26; c++) begin
      chk("gap_ov",    32'(rec_ov[c]), 32'((c >= 2 && c <= 9) || (c >= 13 && c <= 20)));
      chk("gap_ready", 32'(rec_dr[c]), 32'(!(c >= 2 && c <= 11)));
      chk("gap_busy",  32'(rec_bz[c]), 32'(c >= 1 && c <= 23));
      if (c >= 2 && c <= 9)        chk("gap_bit1", 32'(rec_so[c]), 32'(s16[17-c]));
      else if (c >= 13 && c <= 20) chk("gap_bit2", 32'(rec_so[c]), 32'(s16[20-c]));
      else                         chk("gap_idle", 32'(rec_so[c]), 32'd0);
    end

    // Backpressure on the GAP=3 instance: three words, junk data while not ready.
    stream(2, 8'h81, 8'h7E, 8'h42, 3, 45);
    got   = '0;
    nbits = 0;
    for (int c = 0; c < 45; c++) begin
      if (rec_ov[c]) begin
        got = {got[22:0], rec_so[c]};
        nbits++;
      end
    end
    chk("bp_nbits",  32'(nbits), 32'd24);
    chk("bp_stream", 32'(got), 32'h817E42);
    chk("bp_idle",   32'(rec_bz[44]), 32'd0);

    // Reset during bit 4 of AA while 55 waits in the hold register.
    dv[0]  = 1'b1;
    din[0] = 8'hAA;
    @(posedge clk); #1;
    din[0] = 8'h55;
    @(posedge clk); #1;
    dv[0]  = 1'b0;
    din[0] = 8'h00;
    repeat (4) @(posedge clk);
    #2;
    chk("rst_pre_ov",    32'(ov[0]), 32'd1);
    chk("rst_pre_bit",   32'(so[0]), 32'd1);
    chk("rst_pre_ready", 32'(dr[0]), 32'd0);
    chk("rst_pre_busy",  32'(bz[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_out",   32'(so[0]), 32'd0);
    chk("rst_async_ov",    32'(ov[0]), 32'd0);
    chk("rst_async_busy",  32'(bz[0]), 32'd0);
    chk("rst_async_ready", 32'(dr[0]), 32'd1);
    chk("rst_async_last",  32'(lb[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_ov",   32'(ov[0]), 32'd0);
      chk("post_rst_busy", 32'(bz[0]), 32'd0);
    end
    @(posedge clk); #1;
    run_word(0, 8'h96, 8'h96, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
